adc_spi_responder: RTL
======================

ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of flip-flop synchronizer stages on ADC_SCLK, ADC_CS_N and ADC_DIN (legal range 2..4).
REQ-002 SHALL have port CLOCK, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port RESET, input, 1, an asynchronous, active-low reset.
REQ-004 SHALL have ports CH0..CH7, input, 12 each, the sample values served for channels 0..7.
REQ-005 SHALL have port ADC_SCLK, input, 1, the serial clock from the ADC controller (asynchronous to CLOCK).
REQ-006 SHALL have port ADC_CS_N, input, 1, the active-low frame select from the controller.
REQ-007 SHALL have port ADC_DIN, input, 1, the control bits from the controller.
REQ-008 SHALL have port ADC_DOUT, output, 1, the serial conversion data to the controller.
REQ-009 SHALL have port CUR_ADDR, output, 3, the channel served in the current or next frame.
REQ-010 SHALL have port FRAME_DONE, output, 1, a one-CLOCK pulse when a full 16-bit frame completes.
REQ-011 SHALL have port FRAME_ABORT, output, 1, a one-CLOCK pulse when ADC_CS_N rises mid-frame.

Function
REQ-012 SHALL pass ADC_SCLK, ADC_CS_N and ADC_DIN through SYNC_STAGES-flop synchronizers, then one further register for edge detection; all protocol actions act on the synchronized signals.
REQ-013 SHALL operate correctly when the CLOCK frequency is at least 8x the ADC_SCLK frequency; no behaviour is defined below that ratio.
REQ-014 SHALL implement states IDLE and SHIFT, plus a terminal sub-state DONE that waits for ADC_CS_N high.
REQ-015 IDLE -> SHIFT on a synchronized ADC_CS_N falling edge: load shift_reg[15:0] <= {4'b0000, CHn} with n = CUR_ADDR, clear bit_cnt to 0, and freeze the sample for the whole frame.
REQ-016 SHALL drive ADC_DOUT = shift_reg[15] in SHIFT/DONE and 0 in IDLE.
REQ-017 In SHIFT, on each synchronized ADC_SCLK rising edge: bit_cnt increments; when bit_cnt is 2, 3 or 4 before the increment, the sampled ADC_DIN goes to next_addr[2], [1], [0] respectively.
REQ-018 In SHIFT, on each synchronized ADC_SCLK falling edge: shift_reg shifts left by one with a 0 fill; a falling edge before the first rising edge of the frame is ignored.
REQ-019 On the 16th rising edge (bit_cnt 15 -> 16): CUR_ADDR <= next_addr, FRAME_DONE pulses for one cycle, state -> DONE.
REQ-020 In DONE, further SCLK edges are ignored, ADC_DOUT holds 0 (all bits shifted out), and the block goes to IDLE on ADC_CS_N high.
REQ-021 ADC_CS_N rising in SHIFT with bit_cnt < 16: state -> IDLE, FRAME_ABORT pulses, CUR_ADDR is unchanged, next_addr is discarded.
REQ-022 A CS_N edge and an SCLK edge detected in the same cycle: the CS_N edge takes priority and the SCLK edge is discarded.
REQ-023 Changes on CHx after the frame load do not affect the frame in progress.
REQ-024 Master-side timing is fixed as: controller updates ADC_DIN and samples ADC_DOUT on SCLK rising edges; this block updates ADC_DOUT on SCLK falling edges.

Reset
REQ-025 While RESET = 0, the block SHALL be held in this state: state = IDLE, shift_reg = 0, bit_cnt = 0, next_addr = 0, CUR_ADDR = 0, ADC_DOUT = 0, FRAME_DONE = 0, FRAME_ABORT = 0, all synchronizer flops = 1 (CS_N/SCLK idle high).
REQ-026 Reset assertion mid-frame SHALL abort the frame immediately without a FRAME_ABORT pulse; after release the first frame serves channel 0.

Verification
REQ-027 Reset then frame with DIN = 0, CH0 = 12'hA5C -> DOUT bits 0000_1010_0101_1100 on rising edges 1..16, FRAME_DONE pulses once, CUR_ADDR = 0.
REQ-028 Frame 1 with DIN address bits = 3'b101, CH5 = 12'h123 -> CUR_ADDR = 5 after frame 1; frame 2 DOUT = 16'h0123.
REQ-029 CS_N rises after 8 SCLK cycles, with address bits = 3'b111 -> FRAME_ABORT pulses, FRAME_DONE stays 0, CUR_ADDR unchanged, DOUT = 0 in IDLE.
REQ-030 CH0 changes from 12'hFFF to 12'h000 mid-frame -> frame still outputs 16'h0FFF.
REQ-031 20 SCLK cycles within one CS_N low window -> only the first 16 are used, one FRAME_DONE, DOUT = 0 for cycles 17..20.
REQ-032 RESET asserted at SCLK cycle 6, with address bits = 3'b011 -> all outputs zero within the same CLOCK, no pulses; next frame serves CH0.

Source files
------------

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: serial responder that emulates an 8-channel 12-bit SPI ADC.
// The controller's SCLK/CS_N/DIN are synchronised into CLOCK, edge-detected,
// and a 16-bit frame {4'b0, CHn} is shifted out MSB first on SCLK falling edges.
// The channel for the next frame is taken from DIN on rising edges 3, 4 and 5.
//
// Handshake: there is no valid/ready pair. A frame is framed by ADC_CS_N low;
// FRAME_DONE / FRAME_ABORT are single-cycle strobes in the CLOCK domain that
// carry no back-pressure.
module adc_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [11:0] CH0,
    input  logic [11:0] CH1,
    input  logic [11:0] CH2,
    input  logic [11:0] CH3,
    input  logic [11:0] CH4,
    input  logic [11:0] CH5,
    input  logic [11:0] CH6,
    input  logic [11:0] CH7,
    input  logic        ADC_SCLK,
    input  logic        ADC_CS_N,
    input  logic        ADC_DIN,
    output logic        ADC_DOUT,
    output logic [2:0]  CUR_ADDR,
    output logic        FRAME_DONE,
    output logic        FRAME_ABORT,
    output logic [1:0]  DBG_STATE
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, din_sync_q;
    logic        sclk_prev_q, cs_prev_q;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  naddr_q, naddr_d;
    logic [2:0]  cur_q, cur_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;
    logic [11:0] ch_sel;

    logic sclk_s, cs_s, din_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    // Synchronisers plus one edge-detect register; all idle high out of reset.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            sclk_sync_q <= '1;
            cs_sync_q   <= '1;
            din_sync_q  <= '1;
            sclk_prev_q <= 1'b1;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], ADC_SCLK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], ADC_CS_N};
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], ADC_DIN};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    // DIN is taken from the same synchroniser depth as SCLK so both stay aligned.
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign din_s     = din_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    // Channel mux selecting the sample to load at the start of a frame.
    always_comb begin
        ch_sel = CH0;
        case (cur_q)
            3'd0: ch_sel = CH0;
            3'd1: ch_sel = CH1;
            3'd2: ch_sel = CH2;
            3'd3: ch_sel = CH3;
            3'd4: ch_sel = CH4;
            3'd5: ch_sel = CH5;
            3'd6: ch_sel = CH6;
            3'd7: ch_sel = CH7;
            default: ch_sel = CH0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; CS_N edges win over a coincident SCLK edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cs_fall) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (cs_rise)                              state_d = ST_IDLE;
                else if (sclk_rise && cnt_q == 5'd15)     state_d = ST_DONE;
            end
            ST_DONE:  if (cs_s) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath next values; shift_q is kept zero outside a
    // live frame so DOUT can come straight from a flop.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        naddr_d = naddr_q;
        cur_d   = cur_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    shift_d = {4'b0000, ch_sel};
                    cnt_d   = 5'd0;
                    naddr_d = 3'd0;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    abort_d = 1'b1;
                    shift_d = 16'd0;
                end else if (sclk_rise) begin
                    cnt_d = cnt_q + 5'd1;
                    case (cnt_q)
                        5'd2:    naddr_d[2] = din_s;
                        5'd3:    naddr_d[1] = din_s;
                        5'd4:    naddr_d[0] = din_s;
                        default: ;
                    endcase
                    if (cnt_q == 5'd15) begin
                        cur_d   = naddr_q;
                        done_d  = 1'b1;
                        shift_d = 16'd0;
                    end
                end else if (sclk_fall && cnt_q != 5'd0) begin
                    shift_d = {shift_q[14:0], 1'b0};
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            shift_q <= 16'd0;
            cnt_q   <= 5'd0;
            naddr_q <= 3'd0;
            cur_q   <= 3'd0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            naddr_q <= naddr_d;
            cur_q   <= cur_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign ADC_DOUT    = shift_q[15];
    assign CUR_ADDR    = cur_q;
    assign FRAME_DONE  = done_q;
    assign FRAME_ABORT = abort_q;
    assign DBG_STATE   = state_q;

endmodule
